adder_share_arb: RTL and testbench

- Shares one WIDTH-bit carry-increment adder (an internal CIA instance) between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle. The sum, carry and winner ID are registered into a one-deep output stage with its own valid/ready handshake.
- Sits between the lane datapaths and the shared arithmetic resource.

---
 rtl/adder_share_arb.sv | 191 +++++++++++++++++++
 tb/tb_adder_share_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// adder_share_arb: one carry-increment adder shared by NREQ requesters.
// A round-robin arbiter picks one operand pair per cycle; the sum, carry
// and winner ID land in a one-deep output register with valid/ready.
//
// Optional feature: define ADDARB_SAT_EN to saturate rsp_sum to all ones
// whenever the addition carries out (rsp_carry then flags saturation).
// Without the macro the sum is the plain modular sum.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. A requester holds req_valid and its
// operands stable until it sees req_ready, and never derives req_valid from
// req_ready. req_ready is a pure function of the current req_valid, the
// round-robin pointer and the output-stage state, so a grant is stable for
// the whole cycle. rsp_sum/rsp_carry/rsp_id are stable while rsp_valid is
// high and rsp_ready is low.

// Carry-increment adder built from 4-bit blocks. Every block adds its
// slice assuming carry-in 0; the incoming block carry then increments the
// block result, and the block carries out if it generated a carry itself
// or if it was all ones and received a carry.
module adder_share_arb_cia #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = WIDTH / 4;

  logic [NBLK:0] blk_carry;

  assign blk_carry[0] = cin;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic [4:0] raw;
    logic [3:0] inc;

    // Block sum with an implicit carry-in of zero.
    assign raw = {1'b0, a[j*4 +: 4]} + {1'b0, b[j*4 +: 4]};
    // Increment by the incoming block carry.
    assign inc = raw[3:0] + {3'b000, blk_carry[j]};
    assign sum[j*4 +: 4] = inc;
    // Generated carry, or an all-ones block propagating the incoming one.
    assign blk_carry[j+1] = raw[4] | (blk_carry[j] & (&raw[3:0]));
  end

  assign cout = blk_carry[NBLK];

endmodule

module adder_share_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [IDW-1:0]        rsp_id
);

  // Reject configurations the adder and the ID encoding cannot support.
  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("adder_share_arb: WIDTH must be a multiple of 4 and at least 8");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("adder_share_arb: NREQ must be in 2..8");
  end

  // Round-robin pointer: the requester searched first in the next grant.
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;

  logic             load_en;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [NREQ-1:0]  grant;
  logic [IDW:0]     arb_idx;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic [WIDTH-1:0] load_sum;

  // The output stage can take a new result when empty or being drained.
  assign load_en = !rsp_valid || rsp_ready;

  // Round-robin search starting at ptr and wrapping mod NREQ. arb_idx is
  // one bit wider than an ID so ptr + offset never overflows before wrap.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    if (load_en) begin
      for (int o = 0; o < NREQ; o++) begin
        arb_idx = {1'b0, ptr} + (IDW+1)'(o);
        if (arb_idx >= (IDW+1)'(NREQ)) begin
          arb_idx = arb_idx - (IDW+1)'(NREQ);
        end
        if (!grant_any && req_valid[arb_idx[IDW-1:0]]) begin
          grant_any = 1'b1;
          grant_id  = arb_idx[IDW-1:0];
        end
      end
    end
  end

  // Expand the winning ID into a one-hot grant vector.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && (grant_id == IDW'(i))) begin
        grant[i] = 1'b1;
      end
    end
  end

  // No requester may see a grant while the block is held in reset.
  assign req_ready = grant & {NREQ{rst_n}};

  // AND-OR operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
        sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder_share_arb_cia #(
    .WIDTH (WIDTH)
  ) u_cia (
    .a    (sel_a),
    .b    (sel_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_carry)
  );

  // Value written into rsp_sum on a grant.
  always_comb begin
`ifdef ADDARB_SAT_EN
    load_sum = add_carry ? {WIDTH{1'b1}} : add_sum;
`else
    load_sum = add_sum;
`endif
  end

  // Priority moves to the requester just after the winner.
  always_comb begin
    ptr_next = ptr;
    if (grant_any) begin
      ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Output register and pointer: load on a grant, otherwise drain when
  // the consumer takes the result; data holds its last value after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (grant_any) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= load_sum;
      rsp_carry <= add_carry;
      rsp_id    <= grant_id;
      ptr       <= ptr_next;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Testbench for adder_share_arb (WIDTH=32, NREQ=4): directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_adder_share_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int EW    = WIDTH + 1 + IDW;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [IDW-1:0]        rsp_id;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  adder_share_arb #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic            m_valid;
  logic [WIDTH-1:0] m_sum;
  logic            m_carry;
  int              m_id;
  int              m_ptr;
  int              m_last_grant;
  logic [NREQ-1:0] last_rdy;
  logic [EW-1:0]   exp_q [$];

  task automatic model_reset();
    m_valid      = 1'b0;
    m_sum        = '0;
    m_carry      = 1'b0;
    m_id         = 0;
    m_ptr        = 0;
    m_last_grant = -1;
    exp_q.delete();
  endtask

  // Expected result of adding a pair, from plain wide arithmetic.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    full = {1'b0, a} + {1'b0, b};
`ifdef ADDARB_SAT_EN
    if (full[WIDTH]) full[WIDTH-1:0] = '1;
`endif
    return full;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, compare, advance the model to
  // the state it will have after the next rising edge, wait for the next
  // falling edge.
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int g;
    logic [WIDTH:0] res;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] front;
    req_valid = v;
    rsp_ready = rr;
    #1;
    g = -1;
    if (!m_valid || rr) begin
      for (int o = 0; o < NREQ; o++) begin
        int i;
        i = (m_ptr + o) % NREQ;
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_rdy = req_ready;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_sum", rsp_sum, m_sum);
    check("rsp_carry", rsp_carry, m_carry);
    check("rsp_id", rsp_id, m_id);
    if (m_valid && rr) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        front = exp_q.pop_front();
        check("sb_result", {rsp_id, rsp_carry, rsp_sum}, front);
      end
    end
    m_last_grant = g;
    if (g >= 0) begin
      res     = ref_add(op_a[g], op_b[g]);
      m_valid = 1'b1;
      m_sum   = res[WIDTH-1:0];
      m_carry = res[WIDTH];
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
      exp_q.push_back({IDW'(g), res[WIDTH], res[WIDTH-1:0]});
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    check("rst_ready_hold", req_ready, 0);
    check("rst_outs", {rsp_valid, rsp_carry, rsp_id, rsp_sum}, 0);
    model_reset();
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] pend;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Single request from requester 2.
    op_a[2] = 32'h0000_0005;
    op_b[2] = 32'h0000_0003;
    step(4'b0100, 1'b1);
    check("single_rdy", last_rdy, 4'b0100);
    check("single_res", {rsp_valid, rsp_id, rsp_carry, rsp_sum}, {1'b1, 2'd2, 1'b0, 32'h0000_0008});

    // Carry chain, requester 0 alone (pointer currently at 3).
    op_a[0] = 32'h0000_0FFF;
    op_b[0] = 32'h0000_0001;
    step(4'b0001, 1'b1);
    check("carry_mid", {rsp_carry, rsp_sum}, {1'b0, 32'h0000_1000});
    op_a[0] = 32'hFFFF_FFFF;
    op_b[0] = 32'h0000_0001;
    step(4'b0001, 1'b1);
`ifdef ADDARB_SAT_EN
    check("carry_top", {rsp_carry, rsp_sum}, {1'b1, 32'hFFFF_FFFF});
`else
    check("carry_top", {rsp_carry, rsp_sum}, {1'b1, 32'h0000_0000});
`endif
    step(4'b0000, 1'b1);

    // Round robin with everyone requesting, from reset.
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = rand_op();
      op_b[i] = rand_op();
    end
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b1);
      check("rr_id", rsp_id, k % NREQ);
      check("rr_valid", rsp_valid, 1);
    end
    step(4'b0000, 1'b1);

    // Backpressure: hold 0x12345678 for three cycles.
    op_a[0] = 32'h1234_5678;
    op_b[0] = 32'h0000_0000;
    step(4'b0001, 1'b1);
    op_a[1] = rand_op();
    op_b[1] = rand_op();
    op_a[3] = rand_op();
    op_b[3] = rand_op();
    for (int k = 0; k < 3; k++) begin
      step(4'b1010, 1'b0);
      check("bp_rdy", last_rdy, 0);
      check("bp_hold", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd0, 32'h1234_5678});
    end
    step(4'b1010, 1'b1);
    check("bp_release_rdy", last_rdy, 4'b0010);
    check("bp_reload", {rsp_valid, rsp_id}, {1'b1, 2'd1});
    step(4'b0000, 1'b1);

    // Reset while a result is held under backpressure.
    op_a[1] = rand_op();
    op_b[1] = rand_op();
    step(4'b0010, 1'b1);
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("mid_pre_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", rsp_valid, 0);
    check("mid_rst_rdy", req_ready, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    op_a[0] = rand_op();
    op_b[0] = rand_op();
    step(4'b0011, 1'b1);
    check("mid_first_win", last_rdy, 4'b0001);

    // Randomized traffic: requesters hold their pair until granted.
    pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          op_a[i] = rand_op();
          op_b[i] = rand_op();
        end
      end
      step(pend, $urandom_range(0, 3) != 0);
      if (m_last_grant >= 0) pend[m_last_grant] = 1'b0;
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("sb_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
